// File: rtl/udp_axis_pkg.sv
// Shared types for the byte-stream arbiter and its neighbours on the
// SRIO/UDP bridge path. The package provides the arbiter state enum and the
// pad byte that is emitted on a stall timeout.
package udp_axis_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    FLUSH = 2'd2
  } arb_state_t;

  localparam logic [7:0] PAD_BYTE = 8'h00;

endpackage : udp_axis_pkg

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder. It grants the first set bit of req,
// searching from index ptr upward and wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_id,
  output logic         gnt_any
);

  // The search walks offsets from farthest to nearest, so the requester
  // nearest to ptr overwrites all the others.
  always_comb begin
    logic [W-1:0] idx;
    idx     = '0;
    gnt_id  = '0;
    gnt_any = |req;
    for (int k = N - 1; k >= 0; k--) begin
      idx    = W'((int'(ptr) + k) % N);
      gnt_id = req[idx] ? idx : gnt_id;
    end
  end

endmodule : rr_pick

// File: rtl/axis8_pkt_arbiter.sv
// axis8_pkt_arbiter: packet-granular round-robin arbiter onto one 8-bit
// AXI-Stream byte path. The arbiter holds a grant for a whole packet. When a
// packet reaches MAX_PKT_LEN bytes it forces tlast and then drains the rest of
// that source packet.
// Optional feature macro: ARB_STALL_TIMEOUT_EN. When this macro is defined and
// the granted source stalls for TIMEOUT_CYC cycles, the arbiter ends the
// packet with a pad byte. It then drains the rest of that source packet.
module axis8_pkt_arbiter
  import udp_axis_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int MAX_PKT_LEN = 1500,
  parameter int LEN_W       = 11,
  parameter int TIMEOUT_CYC = 256,
  parameter int SRC_W       = $clog2(N_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC*8-1:0] s_tdata,
  input  logic [N_SRC-1:0]   s_tvalid,
  input  logic [N_SRC-1:0]   s_tlast,
  output logic [N_SRC-1:0]   s_tready,
  output logic [7:0]         m_tdata,
  output logic               m_tvalid,
  output logic               m_tlast,
  input  logic               m_tready,
  output logic [SRC_W-1:0]   m_tsrc,
  output logic               grant_active,
  output logic               pkt_trunc
);

  arb_state_t       state_q, state_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  logic [SRC_W-1:0] gnt_id_s;
  logic             gnt_any_s;
  logic [7:0]       sel_data_s;
  logic             sel_valid_s;
  logic             sel_last_s;
  logic             at_max_s;
  logic             pad_active_s;
  logic             xfer_s;
  logic [SRC_W-1:0] ptr_next_s;

  rr_pick #(
    .N (N_SRC),
    .W (SRC_W)
  ) u_rr_pick (
    .req     (s_tvalid),
    .ptr     (ptr_q),
    .gnt_id  (gnt_id_s),
    .gnt_any (gnt_any_s)
  );

  // This block selects the data and control of the granted source. It is
  // zero-latency because the path has no buffering.
  always_comb begin
    sel_data_s  = s_tdata[{src_q, 3'b000} +: 8];
    sel_valid_s = s_tvalid[src_q];
    sel_last_s  = s_tlast[src_q];
  end

  assign at_max_s   = (cnt_q == LEN_W'(MAX_PKT_LEN - 1));
  assign ptr_next_s = (src_q == SRC_W'(N_SRC - 1)) ? '0 : src_q + SRC_W'(1);
  assign xfer_s     = (state_q == PASS) && !pad_active_s && sel_valid_s && m_tready;
  assign m_tsrc     = src_q;

`ifdef ARB_STALL_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               pad_q, pad_d;

  // This block is the stall watchdog. It counts idle cycles of the granted
  // source and arms the pad beat when the limit is reached.
  always_comb begin
    stall_d = stall_q;
    pad_d   = pad_q;
    if (state_q != PASS) begin
      stall_d = '0;
      pad_d   = 1'b0;
    end else if (pad_q) begin
      if (m_tready) begin
        pad_d   = 1'b0;
        stall_d = '0;
      end else begin
        pad_d   = 1'b1;
      end
    end else if (xfer_s) begin
      stall_d = '0;
    end else if (!sel_valid_s) begin
      if (stall_q == STALL_W'(TIMEOUT_CYC - 1)) begin
        stall_d = '0;
        pad_d   = 1'b1;
      end else begin
        stall_d = stall_q + STALL_W'(1);
      end
    end else begin
      stall_d = stall_q;
    end
  end

  // This block holds the watchdog state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      pad_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      pad_q   <= pad_d;
    end
  end

  assign pad_active_s = pad_q;
`else
  assign pad_active_s = 1'b0;
`endif

  // This block decodes the arbiter FSM. It produces the next state and the
  // output-side handshakes.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    s_tready     = '0;
    m_tdata      = 8'h00;
    m_tvalid     = 1'b0;
    m_tlast      = 1'b0;
    pkt_trunc    = 1'b0;
    grant_active = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any_s) begin
          src_d   = gnt_id_s;
          cnt_d   = '0;
          state_d = PASS;
        end else begin
          state_d = IDLE;
        end
      end
      PASS: begin
        grant_active = 1'b1;
        if (pad_active_s) begin
          // The pad beat stands in for the stalled source's byte and closes the packet.
          m_tdata  = PAD_BYTE;
          m_tvalid = 1'b1;
          m_tlast  = 1'b1;
          if (m_tready) begin
            pkt_trunc = 1'b1;
            cnt_d     = '0;
            state_d   = FLUSH;
          end else begin
            state_d   = PASS;
          end
        end else begin
          m_tdata          = sel_data_s;
          m_tvalid         = sel_valid_s;
          m_tlast          = sel_last_s | at_max_s;
          s_tready[src_q]  = m_tready;
          if (xfer_s) begin
            if (sel_last_s) begin
              // A source tlast is a normal end, even on the final allowed byte.
              state_d = IDLE;
              ptr_d   = ptr_next_s;
              cnt_d   = '0;
            end else if (at_max_s) begin
              pkt_trunc = 1'b1;
              cnt_d     = '0;
              state_d   = FLUSH;
            end else begin
              cnt_d     = cnt_q + LEN_W'(1);
            end
          end else begin
            state_d = PASS;
          end
        end
      end
      FLUSH: begin
        // The arbiter drops the rest of the source packet without presenting it downstream.
        s_tready[src_q] = 1'b1;
        if (sel_valid_s && sel_last_s) begin
          state_d = IDLE;
          ptr_d   = ptr_next_s;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // This block holds the FSM, grant and byte-count registers. Reset drops any
  // grant that is in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : axis8_pkt_arbiter

// File: tb/tb_axis8_pkt_arbiter.sv
// Directed self-checking bench for axis8_pkt_arbiter. The sources are models
// driven from per-source byte queues. Expected output beats go into a
// scoreboard queue as stimulus is loaded, and the bench checks them when the
// DUT transfers a beat.
module tb_axis8_pkt_arbiter;

  localparam int NS   = 4;
  localparam int MAXL = 8;
  localparam int TOC  = 16;

  logic        clk;
  logic        reset;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid;
  logic [3:0]  s_tlast;
  logic [3:0]  s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic [1:0]  m_tsrc;
  logic        grant_active;
  logic        pkt_trunc;

  axis8_pkt_arbiter #(
    .N_SRC       (NS),
    .MAX_PKT_LEN (MAXL),
    .LEN_W       (4),
    .TIMEOUT_CYC (TOC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tlast      (m_tlast),
    .m_tready     (m_tready),
    .m_tsrc       (m_tsrc),
    .grant_active (grant_active),
    .pkt_trunc    (pkt_trunc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {logic [7:0] data; logic last;} beat_t;
  typedef struct packed {logic [1:0] src; logic [7:0] data; logic last;} exp_t;

  beat_t srcq [NS][$];
  exp_t  sb[$];
  int    hold_at [NS];
  int    sent [NS];
  int    vectors = 0;
  int    errors = 0;
  int    beats = 0;
  int    trunc_seen = 0;
  bit    rdy_toggle = 1'b0;

  logic [3:0] snap_tready;
  logic       snap_mvalid, snap_mlast, snap_grant, snap_trunc;
  logic [7:0] snap_mdata;
  logic [1:0] snap_tsrc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < NS; i++) begin
      if (srcq[i].size() > 0 && !(hold_at[i] >= 0 && sent[i] == hold_at[i])) begin
        s_tvalid[i]        = 1'b1;
        s_tdata[8*i +: 8]  = srcq[i][0].data;
        s_tlast[i]         = srcq[i][0].last;
      end else begin
        s_tvalid[i]        = 1'b0;
        s_tdata[8*i +: 8]  = 8'h00;
        s_tlast[i]         = 1'b0;
      end
    end
  endtask

  // One clock: sample and score at the negedge, then update the sources just after the posedge.
  task automatic cycle();
    logic [3:0] fire;
    exp_t       e;
    beat_t      dummy;
    @(negedge clk);
    fire        = s_tvalid & s_tready;
    snap_tready = s_tready;
    snap_mvalid = m_tvalid;
    snap_mlast  = m_tlast;
    snap_mdata  = m_tdata;
    snap_tsrc   = m_tsrc;
    snap_grant  = grant_active;
    snap_trunc  = pkt_trunc;
    if (!reset) begin
      if (m_tvalid && m_tready) begin
        beats++;
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("beat_data", 32'(m_tdata), 32'(e.data));
          chk("beat_last", 32'(m_tlast), 32'(e.last));
          chk("beat_src",  32'(m_tsrc),  32'(e.src));
        end
      end
      if (pkt_trunc) trunc_seen++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (fire[i] && srcq[i].size() > 0) begin
        dummy = srcq[i].pop_front();
        sent[i]++;
      end
    end
    drive_srcs();
    m_tready = rdy_toggle ? ~m_tready : 1'b1;
  endtask

  task automatic add_src(input int s, input int len, input int base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = 8'(base + k);
      b.last = (k == len - 1);
      srcq[s].push_back(b);
    end
  endtask

  task automatic exp_pkt(input int s, input int len, input int base);
    exp_t e;
    int   n;
    n = (len < MAXL) ? len : MAXL;
    for (int k = 0; k < n; k++) begin
      e.src  = 2'(s);
      e.data = 8'(base + k);
      e.last = (k == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NS; i++) begin
      srcq[i].delete();
      hold_at[i] = -1;
      sent[i]    = 0;
    end
    sb.delete();
    drive_srcs();
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    rdy_toggle = 1'b0;
    m_tready   = 1'b1;
    clear_all();
    cycle();
    cycle();
    reset      = 1'b0;
    beats      = 0;
    trunc_seen = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s_tready"}, 32'(snap_tready), 32'd0);
    chk({tag, "_m_tvalid"}, 32'(snap_mvalid), 32'd0);
    chk({tag, "_m_tlast"},  32'(snap_mlast),  32'd0);
    chk({tag, "_m_tdata"},  32'(snap_mdata),  32'd0);
    chk({tag, "_m_tsrc"},   32'(snap_tsrc),   32'd0);
    chk({tag, "_grant"},    32'(snap_grant),  32'd0);
    chk({tag, "_trunc"},    32'(snap_trunc),  32'd0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done;
    bit empty;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      cycle();
      empty = (sb.size() == 0);
      for (int i = 0; i < NS; i++) empty = empty && (srcq[i].size() == 0);
      done = empty && !snap_grant && !snap_mvalid;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    for (int k = 0; k < budget && beats < n; k++) cycle();
    chk(tag, 32'(beats >= n), 32'd1);
  endtask

  initial begin
    int k;
    int stalled;
    reset    = 1'b1;
    m_tready = 1'b1;
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;

    // Reset state
    do_reset();
    check_zero("rst");

    // 1: single 5-byte packet from src0, one cycle of arbitration latency
    add_src(0, 5, 8'h10);
    exp_pkt(0, 5, 8'h10);
    for (k = 0; k < 10; k++) begin
      cycle();
      if (snap_mvalid) break;
    end
    chk("t1_latency", 32'(k), 32'd2);
    chk("t1_tsrc",    32'(snap_tsrc),  32'd0);
    chk("t1_grant",   32'(snap_grant), 32'd1);
    for (int j = 0; j < 4; j++) cycle();
    chk("t1_back2back", 32'(beats), 32'd5);
    wait_idle("t1_done", 20);

    // 2: all four sources busy, grant order 0,1,2,3,0 with no interleaving
    do_reset();
    add_src(0, 3, 8'h20);
    add_src(0, 3, 8'h28);
    add_src(1, 3, 8'h30);
    add_src(2, 3, 8'h40);
    add_src(3, 3, 8'h50);
    exp_pkt(0, 3, 8'h20);
    exp_pkt(1, 3, 8'h30);
    exp_pkt(2, 3, 8'h40);
    exp_pkt(3, 3, 8'h50);
    exp_pkt(0, 3, 8'h28);
    wait_idle("t2_done", 60);
    chk("t2_beats", 32'(beats), 32'd15);

    // 3: src2 sends 12 bytes, truncated to 8 and the remaining 4 drained
    do_reset();
    add_src(2, 12, 8'h60);
    exp_pkt(2, 12, 8'h60);
    for (k = 0; k < 30 && !snap_trunc; k++) cycle();
    chk("t3_trunc_seen", 32'(snap_trunc), 32'd1);
    chk("t3_trunc_last", 32'(snap_mlast), 32'd1);
    cycle();
    chk("t3_flush_ready",  32'(snap_tready), 32'b0100);
    chk("t3_flush_mvalid", 32'(snap_mvalid), 32'd0);
    wait_idle("t3_done", 30);
    chk("t3_drained",    32'(srcq[2].size()), 32'd0);
    chk("t3_trunc_cnt",  32'(trunc_seen), 32'd1);
    chk("t3_beats",      32'(beats), 32'd8);

    // 3b: tlast on the 8th byte is a normal end, not a truncation
    add_src(0, 8, 8'h70);
    exp_pkt(0, 8, 8'h70);
    wait_idle("t3b_done", 30);
    chk("t3b_trunc_cnt", 32'(trunc_seen), 32'd1);

    // 4: m_tready toggling during a 6-byte packet
    do_reset();
    rdy_toggle = 1'b1;
    add_src(3, 6, 8'h80);
    exp_pkt(3, 6, 8'h80);
    wait_idle("t4_done", 40);
    chk("t4_beats", 32'(beats), 32'd6);
    rdy_toggle = 1'b0;

    // 5: complete a src0 packet, then reset during byte 3 of a src1 packet
    do_reset();
    add_src(0, 3, 8'h90);
    exp_pkt(0, 3, 8'h90);
    wait_idle("t5_pre", 20);
    add_src(1, 6, 8'hA0);
    exp_pkt(1, 6, 8'hA0);
    wait_beats("t5_two_bytes", 5, 20);
    reset = 1'b1;
    cycle();
    cycle();
    check_zero("t5_rst");
    clear_all();
    reset = 1'b0;
    beats = 0;
    add_src(1, 3, 8'hB0);
    add_src(0, 3, 8'hC0);
    exp_pkt(0, 3, 8'hC0);
    exp_pkt(1, 3, 8'hB0);
    wait_idle("t5_done", 30);

    // 6: src3 stalls after byte 2
    do_reset();
    hold_at[3] = 2;
    add_src(3, 5, 8'hD0);
`ifdef ARB_STALL_TIMEOUT_EN
    exp_pkt(3, 2, 8'hD0);
    sb[1].last = 1'b0;
    sb.push_back(exp_t'({2'd3, 8'h00, 1'b1}));
    wait_beats("t6_two_bytes", 2, 20);
    stalled = 0;
    for (k = 0; k < 40; k++) begin
      cycle();
      if (snap_mvalid) break;
      stalled++;
    end
    chk("t6_stall_cycles", 32'(stalled), 32'(TOC));
    chk("t6_pad_data",     32'(snap_mdata), 32'h00);
    chk("t6_pad_last",     32'(snap_mlast), 32'd1);
    chk("t6_pad_trunc",    32'(snap_trunc), 32'd1);
    hold_at[3] = -1;
    wait_idle("t6_done", 30);
    chk("t6_drained",   32'(srcq[3].size()), 32'd0);
    chk("t6_trunc_cnt", 32'(trunc_seen), 32'd1);
    chk("t6_beats",     32'(beats), 32'd3);
`else
    exp_pkt(3, 5, 8'hD0);
    wait_beats("t6_two_bytes", 2, 20);
    stalled = 0;
    for (k = 0; k < 40; k++) begin
      cycle();
      if (!snap_mvalid && snap_grant) stalled++;
    end
    chk("t6_stall_cycles", 32'(stalled), 32'd40);
    chk("t6_grant_held",   32'(snap_grant), 32'd1);
    chk("t6_tsrc_held",    32'(snap_tsrc),  32'd3);
    chk("t6_no_pad",       32'(beats), 32'd2);
    hold_at[3] = -1;
    wait_idle("t6_done", 30);
    chk("t6_trunc_cnt", 32'(trunc_seen), 32'd0);
    chk("t6_beats",     32'(beats), 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_axis8_pkt_arbiter
